planificador_demux: RTL and testbench
=====================================

PLANIFICADOR_DEMUX -- requirements
Module: planificador_demux

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Clk  input  1  rising-edge clock.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 X  input  4  source data word.
REQ-005 Valido  input  1  source word on X is valid.
REQ-006 Listo  output  1  block accepts X this cycle.
REQ-007 Habilita  input  4  per-destination enable mask; bit i enables destination i.
REQ-008 Listo_dest  input  4  destination i can take a word this cycle.
REQ-009 Selector  output  3  demultiplexer select; 000..011 = destination 0..3, 100 = idle.
REQ-010 Dato  output  4  held word, drives the demultiplexer data input.
REQ-011 Valido_dest  output  4  one-hot; bit i = word on Dato is valid for destination i.
REQ-012 Cuenta  output  8  completed-transfer counter.

Function
REQ-013 The FSM SHALL have states REPOSO, BUSCA and ENVIA.
REQ-014 In REPOSO, Listo SHALL be 1 iff Habilita != 0000; Valido&&Listo at an edge SHALL capture X into Dato and move to BUSCA.
REQ-015 In BUSCA, the block SHALL pick the first enabled destination scanning Puntero+1, Puntero+2, ... mod 4; the pick SHALL be loaded into Selector at the next edge and the state SHALL move to ENVIA.
REQ-016 In BUSCA with Habilita == 0000, the block SHALL stay in BUSCA with Selector = 100 and Dato held.
REQ-017 In ENVIA, Valido_dest SHALL be one-hot at bit Selector; Listo_dest[Selector] = 1 at an edge SHALL complete the transfer: Puntero <= Selector, Cuenta += 1, next state REPOSO.
REQ-018 In ENVIA, if Habilita[Selector] drops before completion, the block SHALL return to BUSCA at the next edge, keep Dato, and re-arbitrate from the unchanged Puntero.
REQ-019 Outside ENVIA, Selector SHALL be 100 and Valido_dest SHALL be 0000; Listo SHALL be 0 outside REPOSO.
REQ-020 Latency: a word accepted at edge k SHALL show Valido_dest from edge k+1; the minimum period SHALL be 3 cycles per word.
REQ-021 Cuenta SHALL wrap 255 -> 0 without a flag.
REQ-022 Dato SHALL change only on acceptance in REPOSO.

Reset
REQ-023 While Rst_n = 0: state REPOSO, Selector = 100, Valido_dest = 0000, Dato = 0000, Cuenta = 0, Puntero = 3 (first grant is destination 0), Listo = 0.
REQ-024 Reset asserted mid-ENVIA SHALL drop the pending word with no Cuenta increment.
REQ-025 Following reset release, the first acceptance SHALL be possible at the first rising edge with Rst_n = 1.

Structure
REQ-026 A shared package demux_pkg SHALL hold the state enum, NUM_DEST = 4, ANCHO = 4 and SEL_INACTIVO = 3'b100.
REQ-027 The round-robin pick SHALL be a combinational sub-module arbitro_rr (inputs Habilita, Puntero; outputs index, hay_destino).
REQ-028 All outputs except Listo SHALL be registered.

Verification
REQ-029 Reset, Habilita = 1111, Listo_dest = 1111, X = 1011 for 4 words -> Selector 000, 001, 010, 011 in order, Dato = 1011, Cuenta = 4.
REQ-030 Habilita = 0101, 3 words -> destinations 0, 2, 0; Valido_dest = 0001, 0100, 0001.
REQ-031 Habilita = 0010, Listo_dest = 0000 for 5 cycles then 0010 -> Valido_dest = 0010 held 6 cycles, one transfer, Cuenta += 1.
REQ-032 In ENVIA at destination 2, Habilita changes 1111 -> 1011 -> BUSCA, then Selector = 011, Dato unchanged.
REQ-033 Habilita = 0000 -> Listo = 0, Selector = 100; 256 transfers later -> Cuenta = 0.
REQ-034 Rst_n pulsed low during ENVIA -> Selector = 100, Valido_dest = 0000 immediately (asynchronous), Cuenta = 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin demultiplexer scheduler.
// Every other file in this block imports this package.
package demux_pkg;

    localparam int NUM_DEST = 4;
    localparam int ANCHO    = 4;
    localparam int PTR_W    = $clog2(NUM_DEST);

    localparam logic [2:0] SEL_INACTIVO = 3'b100;

    typedef enum logic [1:0] {
        REPOSO,
        BUSCA,
        ENVIA
    } estado_t;

    function automatic logic [NUM_DEST-1:0] one_hot(input logic [PTR_W-1:0] idx);
        logic [NUM_DEST-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin pick: the first enabled destination after puntero.
// The scan order is puntero+1, puntero+2, ... modulo NUM_DEST.
module arbitro_rr
    import demux_pkg::*;
(
    input  logic [NUM_DEST-1:0] habilita,
    input  logic [PTR_W-1:0]    puntero,
    output logic [PTR_W-1:0]    index,
    output logic                hay_destino
);

    logic [PTR_W-1:0] cand;

    // NOTE: give every combinational output a default before the loop so that no latch is inferred.
    always_comb begin
        index       = '0;
        hay_destino = 1'b0;
        cand        = '0;
        // Walk from the farthest offset to the nearest so the closest enabled
        // destination is written last and wins. Offset NUM_DEST wraps back to puntero.
        for (int k = NUM_DEST; k >= 1; k--) begin
            cand = puntero + PTR_W'(k);
            if (habilita[cand]) begin
                index       = cand;
                hay_destino = 1'b1;
            end
        end
    end

endmodule

// File: rtl/planificador_demux.sv
// Scheduler that holds one source word and delivers it to a round-robin-chosen
// destination through a demultiplexer select; it counts completed transfers.
module planificador_demux
    import demux_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ANCHO-1:0]    x,
    input  logic                valido,
    output logic                listo,
    input  logic [NUM_DEST-1:0] habilita,
    input  logic [NUM_DEST-1:0] listo_dest,
    output logic [2:0]          selector,
    output logic [ANCHO-1:0]    dato,
    output logic [NUM_DEST-1:0] valido_dest,
    output logic [7:0]          cuenta
);

    estado_t          estado;
    logic [PTR_W-1:0] puntero;
    logic [PTR_W-1:0] pick;
    logic             hay_destino;
    logic [PTR_W-1:0] sel_idx;

    arbitro_rr u_arbitro (
        .habilita    (habilita),
        .puntero     (puntero),
        .index       (pick),
        .hay_destino (hay_destino)
    );

    assign sel_idx = selector[PTR_W-1:0];

    // Listo stays combinational so a source sees acceptance in the same cycle;
    // it is gated by rst_n so that it reads 0 for as long as reset is held.
    assign listo = rst_n && (estado == REPOSO) && (habilita != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= REPOSO;
            puntero     <= PTR_W'(NUM_DEST - 1);
            selector    <= SEL_INACTIVO;
            valido_dest <= '0;
            dato        <= '0;
            cuenta      <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (valido && listo) begin
                        dato   <= x;
                        estado <= BUSCA;
                    end
                end
                BUSCA: begin
                    if (hay_destino) begin
                        selector    <= {1'b0, pick};
                        valido_dest <= one_hot(pick);
                        estado      <= ENVIA;
                    end
                end
                ENVIA: begin
                    if (listo_dest[sel_idx]) begin
                        puntero     <= sel_idx;
                        cuenta      <= cuenta + 8'd1;
                        selector    <= SEL_INACTIVO;
                        valido_dest <= '0;
                        estado      <= REPOSO;
                    end else if (!habilita[sel_idx]) begin
                        // Destination withdrawn: keep the word and re-arbitrate from the old pointer.
                        selector    <= SEL_INACTIVO;
                        valido_dest <= '0;
                        estado      <= BUSCA;
                    end
                end
                default: begin
                    selector    <= SEL_INACTIVO;
                    valido_dest <= '0;
                    estado      <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_planificador_demux.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level model.
module tb_planificador_demux;

    logic       clk;
    logic       rst_n;
    logic [3:0] x;
    logic       valido;
    logic       listo;
    logic [3:0] habilita;
    logic [3:0] listo_dest;
    logic [2:0] selector;
    logic [3:0] dato;
    logic [3:0] valido_dest;
    logic [7:0] cuenta;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    planificador_demux dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .valido      (valido),
        .listo       (listo),
        .habilita    (habilita),
        .listo_dest  (listo_dest),
        .selector    (selector),
        .dato        (dato),
        .valido_dest (valido_dest),
        .cuenta      (cuenta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: is a word held, which destination (if any) is granted.
    typedef struct {
        bit         have;
        int         dest;
        int         ptr;
        int         cnt;
        logic [3:0] data;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t s, input logic v, input logic [3:0] xv,
                                          input logic [3:0] hab, input logic [3:0] ld);
        model_t n = s;
        if (!s.have) begin
            if (v && hab != 4'b0) begin
                n.have = 1'b1;
                n.data = xv;
            end
        end else if (s.dest < 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (hab[(s.ptr + k) % 4]) begin
                    n.dest = (s.ptr + k) % 4;
                    break;
                end
            end
        end else if (ld[s.dest]) begin
            n.ptr  = s.dest;
            n.cnt  = (s.cnt + 1) % 256;
            n.have = 1'b0;
            n.dest = -1;
        end else if (!hab[s.dest]) begin
            n.dest = -1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{have: 1'b0, dest: -1, ptr: 3, cnt: 0, data: 4'h0};
        else        m <= model_step(m, valido, x, habilita, listo_dest);
    end

    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            check("m_selector", 32'(selector), m.dest < 0 ? 32'd4 : 32'(m.dest));
            check("m_valido_dest", 32'(valido_dest), m.dest < 0 ? 32'd0 : (32'd1 << m.dest));
            check("m_dato", 32'(dato), 32'(m.data));
            check("m_cuenta", 32'(cuenta), 32'(m.cnt));
            check("m_listo", 32'(listo), 32'(rst_n && !m.have && (habilita != 4'b0)));
        end
    end

    // Advance to the next cycle with a valid destination, bounded by a cycle budget.
    task automatic wait_dest(input string name);
        int n = 0;
        @(negedge clk); #1;
        while (valido_dest == 4'b0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check({name, "_timeout"}, 32'(n < 20), 32'd1);
    endtask

    int         held;
    int         c0;
    logic [2:0] exp_sel [3];
    logic [3:0] exp_vd  [3];

    initial begin
        rst_n = 1'b0; x = '0; valido = 1'b0; habilita = 4'b1111; listo_dest = '0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_selector", 32'(selector), 32'd4);
        check("rst_valido_dest", 32'(valido_dest), 32'd0);
        check("rst_dato", 32'(dato), 32'd0);
        check("rst_cuenta", 32'(cuenta), 32'd0);
        check("rst_listo", 32'(listo), 32'd0);
        rst_n = 1'b1;

        // Four words, all destinations enabled and ready: grants walk 0..3.
        x = 4'b1011; valido = 1'b1; listo_dest = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_dest("rr4");
            check("rr4_selector", 32'(selector), 32'(i));
            check("rr4_dato", 32'(dato), 32'hb);
        end
        valido = 1'b0;
        @(negedge clk); #1;
        check("rr4_cuenta", 32'(cuenta), 32'd4);
        check("rr4_listo", 32'(listo), 32'd1);

        // Only destinations 0 and 2 enabled.
        exp_sel = '{3'd0, 3'd2, 3'd0};
        exp_vd  = '{4'b0001, 4'b0100, 4'b0001};
        habilita = 4'b0101; x = 4'b0101; valido = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_dest("m0101");
            check("m0101_selector", 32'(selector), 32'(exp_sel[i]));
            check("m0101_valido_dest", 32'(valido_dest), 32'(exp_vd[i]));
        end
        valido = 1'b0;
        @(negedge clk); #1;

        // Destination 1 stalls for five cycles, then accepts.
        habilita = 4'b0010; listo_dest = 4'b0000; x = 4'b0111; valido = 1'b1;
        wait_dest("stall");
        valido = 1'b0;
        c0 = int'(cuenta);
        held = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (valido_dest == 4'b0010) held++;
        end
        listo_dest = 4'b0010;
        @(negedge clk); #1;
        check("stall_held", 32'(held), 32'd6);
        check("stall_vd_after", 32'(valido_dest), 32'd0);
        check("stall_cuenta", 32'(cuenta), 32'((c0 + 1) % 256));

        // Enable withdrawn while granted to destination 2: re-arbitrate to 3.
        habilita = 4'b1111; listo_dest = 4'b0000; x = 4'b0110; valido = 1'b1;
        wait_dest("drop");
        valido = 1'b0;
        check("drop_sel2", 32'(selector), 32'd2);
        habilita = 4'b1011;
        @(negedge clk); #1;
        check("drop_busca_sel", 32'(selector), 32'd4);
        check("drop_busca_vd", 32'(valido_dest), 32'd0);
        @(negedge clk); #1;
        check("drop_sel3", 32'(selector), 32'd3);
        check("drop_vd3", 32'(valido_dest), 32'b1000);
        check("drop_dato", 32'(dato), 32'h6);
        listo_dest = 4'b1111;
        @(negedge clk); #1;
        check("drop_done", 32'(valido_dest), 32'd0);

        // Word held while nothing is enabled: stays idle-selected until an enable returns.
        habilita = 4'b0001; listo_dest = 4'b0000; x = 4'b1110; valido = 1'b1;
        @(negedge clk); #1;
        habilita = 4'b0000; valido = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("none_selector", 32'(selector), 32'd4);
            check("none_listo", 32'(listo), 32'd0);
            check("none_dato", 32'(dato), 32'he);
        end
        habilita = 4'b0001; listo_dest = 4'b0001;
        wait_dest("none");
        check("none_sel0", 32'(selector), 32'd0);
        @(negedge clk); #1;

        // Asynchronous reset in the middle of a pending transfer.
        habilita = 4'b1111; listo_dest = 4'b0000; x = 4'b0001; valido = 1'b1;
        wait_dest("arst");
        valido = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_selector", 32'(selector), 32'd4);
        check("arst_valido_dest", 32'(valido_dest), 32'd0);
        check("arst_cuenta", 32'(cuenta), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No enables: not ready. Then 256 back-to-back transfers wrap the counter.
        habilita = 4'b0000; valido = 1'b1;
        #1;
        check("idle_listo", 32'(listo), 32'd0);
        check("idle_selector", 32'(selector), 32'd4);
        habilita = 4'b1111; listo_dest = 4'b1111;
        repeat (765) @(negedge clk);
        #1;
        check("wrap_255", 32'(cuenta), 32'd255);
        repeat (3) @(negedge clk);
        #1;
        check("wrap_0", 32'(cuenta), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n      = ($urandom_range(0, 199) != 0);
            habilita   = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            listo_dest = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            valido     = 1'($urandom_range(0, 1));
            x          = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst_n = 1'b1; valido = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
